pipelined_right_aligner: RTL

Parametrised, pipelined successor to the single-cycle right barrel shifter used for exponent alignment in the add/sub path. It right-shifts a mantissa by a runtime amount in log2 stages of 1, 2, 4, … positions, with optional pipeline registers between stages. It also produces a sticky bit (OR of every bit shifted out) and saturates over-range shift counts. A valid/ready handshake with per-stage bubble collapsing lets it sit between the exponent-compare stage and the mantissa adder at full throughput.

---
 rtl/pipelined_right_aligner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipelined_right_aligner.sv
// Right-aligning barrel shifter with sticky collection, built from log2 shift stages,
// optional inter-stage registers, and a valid/ready chain that collapses bubbles.
module pipelined_right_aligner #(
  parameter int                    DataSize   = 25,
  parameter int                    ShiftWidth = 5,
  parameter logic [ShiftWidth-1:0] RegMask    = 5'b10100,
  parameter int                    TagWidth   = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DataSize-1:0]   Mantissa,
  input  logic [ShiftWidth-1:0] Shifts,
  input  logic [TagWidth-1:0]   InTag,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DataSize-1:0]   Aligned,
  output logic                  Sticky,
  output logic [TagWidth-1:0]   OutTag
);

  for (genvar k = 0; k < ShiftWidth; k++) begin : g_stage
    localparam int Amt    = 2 ** k;
    localparam int SelW   = ShiftWidth - k;
    localparam bit IsLast = (k == ShiftWidth - 1);

    logic [DataSize-1:0] data_i, shifted, data_d, data_o;
    logic [SelW-1:0]     sh_i;
    logic [TagWidth-1:0] tag_i, tag_o;
    logic                sticky_i, sat_i, vld_i, lost, sticky_d, sticky_o, vld_o;
    logic                go, go_nxt;

    if (k == 0) begin : g_head
      assign data_i   = Mantissa;
      assign sticky_i = 1'b0;
      assign sh_i     = Shifts;
      assign sat_i    = (32'(Shifts) >= 32'(DataSize));
      assign tag_i    = InTag;
      assign vld_i    = InValid;
    end else begin : g_link
      assign data_i   = g_stage[k-1].data_o;
      assign sticky_i = g_stage[k-1].sticky_o;
      assign sh_i     = g_stage[k-1].g_fwd.sh_o;
      assign sat_i    = g_stage[k-1].g_fwd.sat_o;
      assign tag_i    = g_stage[k-1].tag_o;
      assign vld_i    = g_stage[k-1].vld_o;
    end

    if (Amt >= DataSize) begin : g_wide
      assign shifted = '0;
      assign lost    = |data_i;
    end else begin : g_narrow
      assign shifted = data_i >> Amt;
      assign lost    = |data_i[Amt-1:0];
    end

    // Saturated counts are resolved in the last stage: OR of remaining data plus sticky is |Mantissa.
    always_comb begin
      data_d   = sh_i[0] ? shifted : data_i;
      sticky_d = sticky_i | (sh_i[0] & lost);
      if (IsLast && sat_i) begin
        data_d   = '0;
        sticky_d = sticky_i | (|data_i);
      end
    end

    if (IsLast) begin : g_tail
      assign go_nxt = OutReady;
    end else begin : g_mid
      assign go_nxt = g_stage[k+1].go;
    end

    if (RegMask[k]) begin : g_reg
      logic [DataSize-1:0] data_q;
      logic [TagWidth-1:0] tag_q;
      logic                sticky_q, vld_q;

      assign go = !vld_q || go_nxt;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          vld_q <= 1'b0;
        end else if (go) begin
          vld_q <= vld_i;
        end
        if (Rst && IsLast) begin
          data_q   <= '0;
          sticky_q <= 1'b0;
          tag_q    <= '0;
        end else if (go) begin
          data_q   <= data_d;
          sticky_q <= sticky_d;
          tag_q    <= tag_i;
        end
      end

      assign data_o   = data_q;
      assign sticky_o = sticky_q;
      assign tag_o    = tag_q;
      assign vld_o    = vld_q;
    end else begin : g_pass
      assign go       = go_nxt;
      assign data_o   = data_d;
      assign sticky_o = sticky_d;
      assign tag_o    = tag_i;
      assign vld_o    = vld_i;
    end

    // Only the still-unused shift bits and the saturate flag travel on to later stages.
    if (!IsLast) begin : g_fwd
      logic [SelW-2:0] sh_o;
      logic            sat_o;
      if (RegMask[k]) begin : g_reg
        logic [SelW-2:0] sh_q;
        logic            sat_q;
        always_ff @(posedge Clk) begin
          if (go) begin
            sh_q  <= sh_i[SelW-1:1];
            sat_q <= sat_i;
          end
        end
        assign sh_o  = sh_q;
        assign sat_o = sat_q;
      end else begin : g_pass
        assign sh_o  = sh_i[SelW-1:1];
        assign sat_o = sat_i;
      end
    end
  end

  assign InReady  = g_stage[0].go;
  assign OutValid = g_stage[ShiftWidth-1].vld_o;
  assign Aligned  = g_stage[ShiftWidth-1].data_o;
  assign Sticky   = g_stage[ShiftWidth-1].sticky_o;
  assign OutTag   = g_stage[ShiftWidth-1].tag_o;

endmodule
